// File: rtl/inst_fetch_sequencer.sv
// Instruction fetch sequencer: drives a registered instruction ROM,
// hides its read latency in a skid buffer and hands words to decode.
module inst_fetch_sequencer #(
   parameter int unsigned        ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] START_PC = 8'h00,
   parameter logic [ADDR_W-1:0] LAST_PC  = 8'h48,
   parameter int unsigned        DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              busy,
   output logic              done
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              infl_q, infl_d;
   logic [ADDR_W-1:0] ifpc_q, ifpc_d;
   logic [PTR_W-1:0]  rd_q, rd_d;
   logic [PTR_W-1:0]  wr_q, wr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, done_q;

   logic [31:0]       dmem_q [DEPTH];
   logic [ADDR_W-1:0] pmem_q [DEPTH];

   logic              redir;
   logic              pop;
   logic              push;
   logic              issue;
   logic              in_range;
   logic [CNT_W-1:0]  occ;

   assign inst_valid = (cnt_q != '0);
   assign inst       = inst_valid ? dmem_q[rd_q] : '0;
   assign inst_pc    = inst_valid ? pmem_q[rd_q] : '0;
   assign rom_addr   = pc_q;
   assign busy       = busy_q;
   assign done       = done_q;

   assign redir    = redirect_valid && (state_q != S_IDLE);
   assign pop      = inst_valid && inst_ready;
   assign push     = infl_q && !redir;
   assign in_range = (pc_q <= LAST_PC);

   // Buffer slots already promised: held words plus the word in flight.
   assign occ   = cnt_q + CNT_W'(infl_q) - CNT_W'(pop);
   assign issue = (state_q == S_FETCH) && in_range
                  && !redir && (occ < DEPTH_C);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      infl_d  = infl_q;
      ifpc_d  = ifpc_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      if (redir) begin
         state_d = S_FETCH;
         pc_d    = redirect_pc & ~ADDR_W'(3);
         infl_d  = 1'b0;
         rd_d    = '0;
         wr_d    = '0;
         cnt_d   = '0;
      end else begin
         infl_d = issue;
         if (issue) begin
            ifpc_d = pc_q;
            pc_d   = pc_q + ADDR_W'(4);
         end
         if (push) wr_d = wr_q + PTR_W'(1);
         if (pop)  rd_d = rd_q + PTR_W'(1);
         if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
         if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_d = S_FETCH;
                  pc_d    = START_PC;
               end
            end
            S_FETCH: begin
               if (!in_range && !infl_q && cnt_q == '0)
                  state_d = S_DONE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= START_PC;
         infl_q  <= 1'b0;
         ifpc_q  <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         infl_q  <= infl_d;
         ifpc_q  <= ifpc_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d == S_FETCH);
         done_q  <= (state_d == S_DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         dmem_q[wr_q] <= rom_data;
         pmem_q[wr_q] <= ifpc_q;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n && push && !pop)
         assert (cnt_q != DEPTH_C);
   end
`endif

endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// Directed bench for inst_fetch_sequencer with a registered ROM model.
// Outputs sampled on the falling edge; inputs driven right after it.
module tb_inst_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  rom_addr;
   logic [31:0] rom_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [7:0]  inst_pc;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        busy;
   logic        done;

   logic [31:0] rom [64];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   inst_fetch_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy           (busy),
      .done           (done)
   );

   always @(posedge clk) rom_data <= rom[rom_addr[7:2]];

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      start          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 8'h00;
      inst_ready     = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   // Leaves the bench at the falling edge of cycle 1.
   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic pulse_redirect(input logic [7:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      cyc();
      redirect_valid = 1'b0;
   endtask

   task automatic expect_inst(input string tag,
                              input logic [31:0] w,
                              input logic [7:0] pc);
      check({tag, " valid"}, 32'(inst_valid), 32'd1);
      check({tag, " inst"}, inst, w);
      check({tag, " pc"}, 32'(inst_pc), 32'(pc));
   endtask

   // Streams with ready high until done; returns transfers and gap.
   task automatic drain(input logic [7:0] pc0,
                        output int n, output int gap);
      int cnt;
      int last;
      n    = 0;
      last = 0;
      cnt  = 0;
      while (!done && cnt < 200) begin
         if (inst_valid && inst_ready) begin
            check("drain pc", 32'(inst_pc), 32'(pc0) + 32'(n * 4));
            check("drain inst", inst, rom[inst_pc[7:2]]);
            n++;
            last = cnt;
         end
         cyc();
         cnt++;
      end
      check("drain done", 32'(done), 32'd1);
      gap = cnt - last;
   endtask

   initial begin
      int n;
      int gap;
      for (int i = 0; i < 64; i++)
         rom[i] = {16'ha500, 8'(i), 8'h13};
      rom[8'h00 >> 2] = 32'h00450693;
      rom[8'h04 >> 2] = 32'h00100713;
      rom[8'h08 >> 2] = 32'h00b76463;
      rom[8'h1c >> 2] = 32'hffc62883;
      rom[8'h20 >> 2] = 32'h01185a63;
      rom[8'h3c >> 2] = 32'h0107a023;
      rom[8'h44 >> 2] = 32'h00468693;
      rom[8'h48 >> 2] = 32'hfc1ff06f;

      // Reset state, and redirect ignored while idle
      cyc();
      do_reset();
      check("rst valid", 32'(inst_valid), 32'd0);
      check("rst inst", inst, 32'd0);
      check("rst pc", 32'(inst_pc), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst addr", 32'(rom_addr), 32'h00);
      pulse_redirect(8'h20);
      cyc();
      check("idle redir busy", 32'(busy), 32'd0);
      check("idle redir addr", 32'(rom_addr), 32'h00);

      // Full program run with ready high
      inst_ready = 1'b1;
      pulse_start();
      check("c1 addr", 32'(rom_addr), 32'h00);
      check("c1 busy", 32'(busy), 32'd1);
      check("c1 valid", 32'(inst_valid), 32'd0);
      cyc();
      check("c2 addr", 32'(rom_addr), 32'h04);
      check("c2 valid", 32'(inst_valid), 32'd0);
      cyc();
      expect_inst("c3", 32'h00450693, 8'h00);
      drain(8'h00, n, gap);
      check("run transfers", 32'(n), 32'd19);
      check("run done gap", 32'(gap), 32'd2);
      check("run busy", 32'(busy), 32'd0);

      // Backpressure
      do_reset();
      pulse_start();
      cyc();
      cyc();
      for (int k = 0; k < 5; k++) begin
         expect_inst("bp hold", 32'h00450693, 8'h00);
         if (k > 0) check("bp addr", 32'(rom_addr), 32'h08);
         cyc();
      end
      inst_ready = 1'b1;
      expect_inst("bp w0", 32'h00450693, 8'h00);
      cyc();
      expect_inst("bp w1", 32'h00100713, 8'h04);
      cyc();
      expect_inst("bp w2", 32'h00b76463, 8'h08);

      // Redirect squashing buffered and in-flight words
      do_reset();
      inst_ready = 1'b1;
      pulse_start();
      cyc();
      cyc();
      expect_inst("rd w0", 32'h00450693, 8'h00);
      cyc();
      expect_inst("rd w1 buffered", 32'h00100713, 8'h04);
      check("rd inflight addr", 32'(rom_addr), 32'h0c);
      inst_ready = 1'b0;
      pulse_redirect(8'h1c);
      inst_ready = 1'b1;
      check("rd c1 valid", 32'(inst_valid), 32'd0);
      check("rd c1 addr", 32'(rom_addr), 32'h1c);
      cyc();
      check("rd c2 valid", 32'(inst_valid), 32'd0);
      cyc();
      expect_inst("rd 1c", 32'hffc62883, 8'h1c);
      cyc();
      expect_inst("rd 20", 32'h01185a63, 8'h20);

      // Misaligned redirect, accepted in the redirect cycle
      pulse_redirect(8'h3e);
      check("ra c1 valid", 32'(inst_valid), 32'd0);
      cyc();
      check("ra c2 valid", 32'(inst_valid), 32'd0);
      cyc();
      expect_inst("ra 3c", 32'h0107a023, 8'h3c);
      drain(8'h3c, n, gap);
      check("ra transfers", 32'(n), 32'd4);

      // Redirect out of DONE
      pulse_redirect(8'h44);
      check("dr busy", 32'(busy), 32'd1);
      check("dr done", 32'(done), 32'd0);
      cyc();
      cyc();
      expect_inst("dr 44", 32'h00468693, 8'h44);
      cyc();
      expect_inst("dr 48", 32'hfc1ff06f, 8'h48);
      cyc();
      check("dr c5 valid", 32'(inst_valid), 32'd0);
      check("dr c5 done", 32'(done), 32'd0);
      cyc();
      check("dr c6 done", 32'(done), 32'd1);
      check("dr c6 busy", 32'(busy), 32'd0);

      // Redirect past the image: nothing fetched
      pulse_redirect(8'h4c);
      check("past busy", 32'(busy), 32'd1);
      check("past valid", 32'(inst_valid), 32'd0);
      check("past addr", 32'(rom_addr), 32'h4c);
      cyc();
      check("past done", 32'(done), 32'd1);
      check("past valid2", 32'(inst_valid), 32'd0);

      // Reset mid-stream with ready toggling
      do_reset();
      pulse_start();
      for (int k = 0; k < 6; k++) begin
         inst_ready = k[0];
         cyc();
      end
      check("mid pre valid", 32'(inst_valid), 32'd1);
      rst_n = 1'b0;
      cyc();
      rst_n      = 1'b1;
      inst_ready = 1'b1;
      check("mid valid", 32'(inst_valid), 32'd0);
      check("mid inst", inst, 32'd0);
      check("mid pc", 32'(inst_pc), 32'd0);
      check("mid busy", 32'(busy), 32'd0);
      check("mid done", 32'(done), 32'd0);
      check("mid addr", 32'(rom_addr), 32'h00);
      cyc();
      check("mid idle valid", 32'(inst_valid), 32'd0);
      pulse_start();
      check("re c1 addr", 32'(rom_addr), 32'h00);
      cyc();
      cyc();
      expect_inst("re w0", 32'h00450693, 8'h00);
      cyc();
      expect_inst("re w1", 32'h00100713, 8'h04);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
